// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
//
// Reset and lock sequencer for the 40 MHz pixel-clock PLL on the VGA path. It runs on the 50 MHz
// reference clock. It pulses the PLL reset and waits for the PLL to report lock. It then requires
// lock to hold for a programmable time before it releases the downstream system reset. If lock is
// lost while running, it re-sequences the PLL. If too many attempts fail in a row, it parks in a
// FAIL state until an external reset or restart.
//
// Parameters:
//   PLL_RST_CYCLES - width of each PLL reset pulse, in refclk cycles (>= 1)
//   LOCK_TIMEOUT   - cycles allowed in WAIT_LOCK before the attempt counts as failed
//   LOCK_STABLE    - consecutive locked cycles required before release
//   MAX_RETRIES    - failed attempts before FAIL (1..15)
//   CNT_W          - shared cycle-counter width
//
// Ports:
//   i_refclk     - reference clock, the only clock
//   i_rst        - synchronous active-high reset
//   i_pll_locked - PLL locked flag, asynchronous to i_refclk
//   i_restart    - one-cycle request to re-sequence the PLL and clear the retry count
//   o_pll_rst    - drives the PLL reset input
//   o_sys_rst    - downstream reset, active-high (always the complement of o_ready)
//   o_ready      - PLL locked and qualified
//   o_fail       - retry budget exhausted
//   o_lock_lost  - one-cycle pulse when lock drops while running
//   o_retry_cnt  - failed attempts since the last successful lock or restart

module pll_lock_supervisor #(
    parameter int unsigned PLL_RST_CYCLES = 10,
    parameter int unsigned LOCK_TIMEOUT   = 50000,
    parameter int unsigned LOCK_STABLE    = 1024,
    parameter int unsigned MAX_RETRIES    = 3,
    parameter int unsigned CNT_W          = 16
) (
    input  logic       i_refclk,
    input  logic       i_rst,
    input  logic       i_pll_locked,
    input  logic       i_restart,
    output logic       o_pll_rst,
    output logic       o_sys_rst,
    output logic       o_ready,
    output logic       o_fail,
    output logic       o_lock_lost,
    output logic [3:0] o_retry_cnt
);

    // Terminal counts: a phase ends on the cycle its counter holds N-1.
    localparam logic [CNT_W-1:0] RstLast     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] StableLast  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] CntOne      = CNT_W'(1);
    localparam logic [CNT_W-1:0] CntZero     = '0;
    localparam logic [3:0]       RetryMax    = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        StResetPll,
        StWaitLock,
        StStabilize,
        StRun,
        StFail
    } state_t;

    // Lock synchroniser
    logic r_sync_meta;
    logic r_sync_lock;
    logic w_lock_s;

    // FSM state and next-state
    state_t           r_state;
    state_t           w_state_d;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_d;
    logic [3:0]       r_retry;
    logic [3:0]       w_retry_d;
    logic [3:0]       w_retry_inc;
    logic             w_attempt_failed;
    logic             w_lock_lost_d;

    // Registered outputs and their next values
    logic r_pll_rst;
    logic r_sys_rst;
    logic r_ready;
    logic r_fail;
    logic r_lock_lost;
    logic w_pll_rst_d;
    logic w_sys_rst_d;
    logic w_ready_d;
    logic w_fail_d;

    assign w_lock_s    = r_sync_lock;
    assign w_retry_inc = r_retry + 4'd1;

    // Next-state logic. restart overrides everything except rst, including a failure
    // that would otherwise be recorded in the same cycle.
    always_comb begin
        w_state_d        = r_state;
        w_cnt_d          = r_cnt;
        w_retry_d        = r_retry;
        w_attempt_failed = 1'b0;
        w_lock_lost_d    = 1'b0;

        if (i_restart) begin
            w_state_d = StResetPll;
            w_cnt_d   = CntZero;
            w_retry_d = 4'd0;
        end else begin
            unique case (r_state)
                StResetPll: begin
                    if (r_cnt == RstLast) begin
                        w_state_d = StWaitLock;
                        w_cnt_d   = CntZero;
                    end else begin
                        w_cnt_d = r_cnt + CntOne;
                    end
                end

                StWaitLock: begin
                    if (w_lock_s) begin
                        w_state_d = StStabilize;
                        w_cnt_d   = CntZero;
                    end else if (r_cnt == TimeoutLast) begin
                        w_attempt_failed = 1'b1;
                    end else begin
                        w_cnt_d = r_cnt + CntOne;
                    end
                end

                StStabilize: begin
                    // Any dropout restarts the whole attempt; lock must be consecutive.
                    if (!w_lock_s) begin
                        w_attempt_failed = 1'b1;
                    end else if (r_cnt == StableLast) begin
                        w_state_d = StRun;
                        w_cnt_d   = CntZero;
                        w_retry_d = 4'd0;
                    end else begin
                        w_cnt_d = r_cnt + CntOne;
                    end
                end

                StRun: begin
                    // Lock loss after qualification is not charged against the retry budget.
                    if (!w_lock_s) begin
                        w_state_d     = StResetPll;
                        w_cnt_d       = CntZero;
                        w_lock_lost_d = 1'b1;
                    end
                end

                StFail: begin
                    // Parked until rst or restart.
                end

                default: begin
                    w_state_d = StResetPll;
                    w_cnt_d   = CntZero;
                end
            endcase

            if (w_attempt_failed) begin
                w_retry_d = w_retry_inc;
                w_cnt_d   = CntZero;
                w_state_d = (w_retry_inc == RetryMax) ? StFail : StResetPll;
            end
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_comb begin
        w_pll_rst_d = 1'b0;
        w_sys_rst_d = 1'b1;
        w_ready_d   = 1'b0;
        w_fail_d    = 1'b0;
        unique case (w_state_d)
            StResetPll: begin
                w_pll_rst_d = 1'b1;
            end
            StWaitLock, StStabilize: begin
                w_pll_rst_d = 1'b0;
            end
            StRun: begin
                w_sys_rst_d = 1'b0;
                w_ready_d   = 1'b1;
            end
            StFail: begin
                w_pll_rst_d = 1'b1;
                w_fail_d    = 1'b1;
            end
            default: begin
                w_pll_rst_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_refclk) begin
        if (i_rst) begin
            r_sync_meta <= 1'b0;
            r_sync_lock <= 1'b0;
            r_state     <= StResetPll;
            r_cnt       <= CntZero;
            r_retry     <= 4'd0;
            r_pll_rst   <= 1'b1;
            r_sys_rst   <= 1'b1;
            r_ready     <= 1'b0;
            r_fail      <= 1'b0;
            r_lock_lost <= 1'b0;
        end else begin
            r_sync_meta <= i_pll_locked;
            r_sync_lock <= r_sync_meta;
            r_state     <= w_state_d;
            r_cnt       <= w_cnt_d;
            r_retry     <= w_retry_d;
            r_pll_rst   <= w_pll_rst_d;
            r_sys_rst   <= w_sys_rst_d;
            r_ready     <= w_ready_d;
            r_fail      <= w_fail_d;
            r_lock_lost <= w_lock_lost_d;
        end
    end

    assign o_pll_rst   = r_pll_rst;
    assign o_sys_rst   = r_sys_rst;
    assign o_ready     = r_ready;
    assign o_fail      = r_fail;
    assign o_lock_lost = r_lock_lost;
    assign o_retry_cnt = r_retry;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor
//
// Bench for pll_lock_supervisor with PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, LOCK_STABLE=8 and
// MAX_RETRIES=3. Each scenario queues per-cycle steps: the inputs to apply before an edge, and the
// outputs required just after that edge. It then drains the queue against the DUT.
// Expected vectors are packed as {pll_rst, sys_rst, ready, fail, lock_lost, retry_cnt[3:0]}.

module tb_pll_lock_supervisor;

    localparam int unsigned PLL_RST_CYCLES = 4;
    localparam int unsigned LOCK_TIMEOUT   = 20;
    localparam int unsigned LOCK_STABLE    = 8;
    localparam int unsigned MAX_RETRIES    = 3;
    localparam int unsigned CNT_W          = 16;

    logic       clk = 1'b0;
    logic       i_rst;
    logic       i_pll_locked;
    logic       i_restart;
    logic       o_pll_rst;
    logic       o_sys_rst;
    logic       o_ready;
    logic       o_fail;
    logic       o_lock_lost;
    logic [3:0] o_retry_cnt;

    typedef struct {
        logic       rst;
        logic       restart;
        logic       locked;
        logic [8:0] exp;
    } step_t;

    step_t sb_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    always #5 clk = ~clk;

    pll_lock_supervisor #(
        .PLL_RST_CYCLES(PLL_RST_CYCLES),
        .LOCK_TIMEOUT  (LOCK_TIMEOUT),
        .LOCK_STABLE   (LOCK_STABLE),
        .MAX_RETRIES   (MAX_RETRIES),
        .CNT_W         (CNT_W)
    ) dut (
        .i_refclk    (clk),
        .i_rst       (i_rst),
        .i_pll_locked(i_pll_locked),
        .i_restart   (i_restart),
        .o_pll_rst   (o_pll_rst),
        .o_sys_rst   (o_sys_rst),
        .o_ready     (o_ready),
        .o_fail      (o_fail),
        .o_lock_lost (o_lock_lost),
        .o_retry_cnt (o_retry_cnt)
    );

    // ready is required to be the complement of sys_rst in every cycle.
    function automatic void push(input logic rst_v, input logic rs, input logic lk,
                                 input logic prst, input logic srst, input logic fl,
                                 input logic ll, input logic [3:0] rc);
        step_t s;
        s.rst     = rst_v;
        s.restart = rs;
        s.locked  = lk;
        s.exp     = {prst, srst, ~srst, fl, ll, rc};
        sb_q.push_back(s);
    endfunction

    function automatic void push_reset();
        push(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    endfunction

    task automatic test_reset();
        step_t      s;
        logic [8:0] act;
        int         k = 0;
        for (int i = 0; i < 3; i++) push_reset();
        while (sb_q.size() > 0) begin
            s = sb_q.pop_front();
            i_rst = s.rst; i_restart = s.restart; i_pll_locked = s.locked;
            @(posedge clk); #1;
            act = {o_pll_rst, o_sys_rst, o_ready, o_fail, o_lock_lost, o_retry_cnt};
            n_tests++;
            if (act !== s.exp) begin
                n_fail++;
                $display("FAIL reset cycle %0d: prst/srst/rdy/fail/lost/retry got %b want %b",
                         k, act, s.exp);
            end
            k++;
        end
    endtask

    // pll_locked first sampled at edge 10 -> STABILIZE at 12 -> RUN at 20.
    task automatic test_bring_up();
        step_t      s;
        logic [8:0] act;
        int         k = 0;
        push_reset();
        for (int c = 1; c <= 23; c++)
            push(1'b0, 1'b0, c >= 10, c <= 3, c < 20, 1'b0, 1'b0, 4'd0);
        while (sb_q.size() > 0) begin
            s = sb_q.pop_front();
            i_rst = s.rst; i_restart = s.restart; i_pll_locked = s.locked;
            @(posedge clk); #1;
            act = {o_pll_rst, o_sys_rst, o_ready, o_fail, o_lock_lost, o_retry_cnt};
            n_tests++;
            if (act !== s.exp) begin
                n_fail++;
                $display("FAIL bring_up cycle %0d: prst/srst/rdy/fail/lost/retry got %b want %b",
                         k, act, s.exp);
            end
            k++;
        end
    endtask

    // Each attempt is a 4-cycle pulse plus a 20-cycle wait; the third failure parks in FAIL.
    task automatic test_timeout();
        step_t      s;
        logic [8:0] act;
        int         k = 0;
        push_reset();
        for (int c = 1; c <= 95; c++) begin
            if (c < 72)
                push(1'b0, 1'b0, 1'b0, (c % 24) < 4, 1'b1, 1'b0, 1'b0, 4'(c / 24));
            else
                push(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd3);
        end
        while (sb_q.size() > 0) begin
            s = sb_q.pop_front();
            i_rst = s.rst; i_restart = s.restart; i_pll_locked = s.locked;
            @(posedge clk); #1;
            act = {o_pll_rst, o_sys_rst, o_ready, o_fail, o_lock_lost, o_retry_cnt};
            n_tests++;
            if (act !== s.exp) begin
                n_fail++;
                $display("FAIL timeout cycle %0d: prst/srst/rdy/fail/lost/retry got %b want %b",
                         k, act, s.exp);
            end
            k++;
        end
    endtask

    // Runs from FAIL left by test_timeout.
    task automatic test_restart_from_fail();
        step_t      s;
        logic [8:0] act;
        int         k = 0;
        for (int c = 0; c <= 18; c++)
            push(1'b0, c == 0, c >= 5, c <= 3, c < 15, 1'b0, 1'b0, 4'd0);
        while (sb_q.size() > 0) begin
            s = sb_q.pop_front();
            i_rst = s.rst; i_restart = s.restart; i_pll_locked = s.locked;
            @(posedge clk); #1;
            act = {o_pll_rst, o_sys_rst, o_ready, o_fail, o_lock_lost, o_retry_cnt};
            n_tests++;
            if (act !== s.exp) begin
                n_fail++;
                $display("FAIL restart_fail cycle %0d: prst/srst/rdy/fail/lost/retry got %b want %b",
                         k, act, s.exp);
            end
            k++;
        end
    endtask

    // STABILIZE entered at edge 8; the one-cycle dropout is seen at edge 13.
    task automatic test_stabilise_glitch();
        step_t      s;
        logic [8:0] act;
        int         k = 0;
        push_reset();
        for (int c = 1; c <= 29; c++)
            push(1'b0, 1'b0, (c >= 6) && (c != 11), (c <= 3) || (c >= 13 && c <= 16),
                 c < 26, 1'b0, 1'b0, (c >= 13 && c < 26) ? 4'd1 : 4'd0);
        while (sb_q.size() > 0) begin
            s = sb_q.pop_front();
            i_rst = s.rst; i_restart = s.restart; i_pll_locked = s.locked;
            @(posedge clk); #1;
            act = {o_pll_rst, o_sys_rst, o_ready, o_fail, o_lock_lost, o_retry_cnt};
            n_tests++;
            if (act !== s.exp) begin
                n_fail++;
                $display("FAIL stab_glitch cycle %0d: prst/srst/rdy/fail/lost/retry got %b want %b",
                         k, act, s.exp);
            end
            k++;
        end
    endtask

    // RUN from edge 15; lock drops at input step 18, so the response appears on edge 20.
    task automatic test_lock_loss();
        step_t      s;
        logic [8:0] act;
        int         k = 0;
        push_reset();
        for (int c = 1; c <= 36; c++)
            push(1'b0, 1'b0, (c >= 5 && c < 18) || c >= 24, (c <= 3) || (c >= 20 && c <= 23),
                 (c < 15) || (c >= 20 && c < 34), 1'b0, c == 20, 4'd0);
        while (sb_q.size() > 0) begin
            s = sb_q.pop_front();
            i_rst = s.rst; i_restart = s.restart; i_pll_locked = s.locked;
            @(posedge clk); #1;
            act = {o_pll_rst, o_sys_rst, o_ready, o_fail, o_lock_lost, o_retry_cnt};
            n_tests++;
            if (act !== s.exp) begin
                n_fail++;
                $display("FAIL lock_loss cycle %0d: prst/srst/rdy/fail/lost/retry got %b want %b",
                         k, act, s.exp);
            end
            k++;
        end
    endtask

    // STABILIZE counter holds 6 after edge 13; rst is sampled at edge 14.
    task automatic test_reset_mid();
        step_t      s;
        logic [8:0] act;
        int         k = 0;
        push_reset();
        for (int c = 1; c <= 29; c++)
            push(c == 14, 1'b0, c >= 5, (c <= 3) || (c >= 14 && c <= 17), c < 27, 1'b0, 1'b0,
                 4'd0);
        while (sb_q.size() > 0) begin
            s = sb_q.pop_front();
            i_rst = s.rst; i_restart = s.restart; i_pll_locked = s.locked;
            @(posedge clk); #1;
            act = {o_pll_rst, o_sys_rst, o_ready, o_fail, o_lock_lost, o_retry_cnt};
            n_tests++;
            if (act !== s.exp) begin
                n_fail++;
                $display("FAIL reset_mid cycle %0d: prst/srst/rdy/fail/lost/retry got %b want %b",
                         k, act, s.exp);
            end
            k++;
        end
    endtask

    // restart coincides with the timeout at edge 24 and again mid-pulse at edge 26.
    task automatic test_back_to_back();
        step_t      s;
        logic [8:0] act;
        int         k = 0;
        push_reset();
        for (int c = 1; c <= 33; c++)
            push(1'b0, (c == 24) || (c == 26), 1'b0, (c <= 3) || (c >= 24 && c <= 29), 1'b1,
                 1'b0, 1'b0, 4'd0);
        while (sb_q.size() > 0) begin
            s = sb_q.pop_front();
            i_rst = s.rst; i_restart = s.restart; i_pll_locked = s.locked;
            @(posedge clk); #1;
            act = {o_pll_rst, o_sys_rst, o_ready, o_fail, o_lock_lost, o_retry_cnt};
            n_tests++;
            if (act !== s.exp) begin
                n_fail++;
                $display("FAIL back_to_back cycle %0d: prst/srst/rdy/fail/lost/retry got %b want %b",
                         k, act, s.exp);
            end
            k++;
        end
    endtask

    initial begin
        i_rst        = 1'b1;
        i_restart    = 1'b0;
        i_pll_locked = 1'b0;
        test_reset();
        test_bring_up();
        test_timeout();
        test_restart_from_fail();
        test_stabilise_glitch();
        test_lock_loss();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Reset and lock sequencer for the 40 MHz pixel-clock PLL used by the VGA path. It runs on the 50 MHz reference clock and drives the PLL `rst` input. It qualifies the PLL `locked` output and holds the downstream system reset until lock has been stable for a programmable time. On lock loss it re-sequences the PLL, and it gives up into a FAIL state after a bounded number of failed attempts.

## Interface
Parameters:
- `PLL_RST_CYCLES`, 10: width of each PLL reset pulse, in refclk cycles (≥1)
- `LOCK_TIMEOUT`, 50000: cycles allowed in WAIT_LOCK before the attempt counts as failed (1 ms at 50 MHz)
- `LOCK_STABLE`, 1024: consecutive locked cycles required before release
- `MAX_RETRIES`, 3: failed attempts before FAIL (1..15)
- `CNT_W`, 16: shared cycle-counter width; must hold max(PLL_RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE)

Ports:
- `refclk` in 1: the single clock, 50 MHz reference
- `rst` in 1: synchronous, active-high reset
- `pll_locked` in 1: PLL `locked`, asynchronous to refclk
- `restart` in 1: one-cycle request to re-sequence the PLL and clear the retry count
- `pll_rst` out 1: drives the PLL `rst` input
- `sys_rst` out 1: downstream reset, active-high; consumers resynchronise it into the pixel domain
- `ready` out 1: PLL locked and qualified
- `fail` out 1: retry budget exhausted
- `lock_lost` out 1: one-cycle pulse when lock drops in RUN
- `retry_cnt` out 4: failed attempts since the last successful lock or restart

## Operation
- `pll_locked` passes through a 2-FF synchroniser to give `lock_s`. The FSM uses only `lock_s`.
- All outputs are registered. Reset values:
  - state = RESET_PLL
  - `pll_rst`=1, `sys_rst`=1
  - `ready`=0, `fail`=0, `lock_lost`=0
  - `retry_cnt`=0, counter=0
- Input priority: `rst` > `restart` > lock events.
- **RESET_PLL**: `pll_rst`=1, `sys_rst`=1. Stays for exactly PLL_RST_CYCLES cycles, then goes to WAIT_LOCK with the counter cleared.
- **WAIT_LOCK**: `pll_rst`=0, `sys_rst`=1.
  - `lock_s`=1: go to STABILIZE, counter cleared.
  - Counter reaches LOCK_TIMEOUT−1 with `lock_s`=0: failed attempt.
- **STABILIZE**: `sys_rst`=1.
  - Counter counts consecutive `lock_s`=1 cycles.
  - Reaches LOCK_STABLE−1: go to RUN.
  - Any `lock_s`=0: failed attempt.
- **Failed attempt**: `retry_cnt`+1. If the new value equals MAX_RETRIES, go to FAIL; otherwise go to RESET_PLL.
- **RUN**: `sys_rst`=0, `ready`=1, `retry_cnt` cleared on entry.
  - `lock_s`=0: pulse `lock_lost` for one cycle and go to RESET_PLL.
  - This does not increment `retry_cnt`.
- **FAIL**: `pll_rst`=1, `sys_rst`=1, `fail`=1, `retry_cnt` frozen. Exits only on `rst` or `restart`.
- **`restart`** in any state: go to RESET_PLL, `retry_cnt`=0, `fail`=0, counter cleared.
  - `restart` during RESET_PLL restarts the pulse count.
- The counter never wraps; it is cleared on every state change.
- `ready` and `sys_rst` are always complementary.

## Timing
- Synchroniser latency is 2 cycles. Outputs change one edge after the FSM samples the triggering `lock_s`.
  - Net result: `pll_locked` edge → `ready`/`sys_rst`/`lock_lost` response = 3 refclk edges, plus any stabilise time.
- From `rst` deassertion, `pll_rst` stays high exactly PLL_RST_CYCLES cycles.
- `ready` rises exactly LOCK_STABLE cycles after the first cycle STABILIZE is occupied.
- A WAIT_LOCK timeout lasts exactly LOCK_TIMEOUT cycles.
- `lock_lost` and the `sys_rst` rise occur on the same edge.
- `rst` mid-operation: all reset values on the next edge. A new PLL reset pulse begins.
- Simultaneous `restart` and timeout/stabilise failure: `restart` wins, `retry_cnt`=0.

## Test plan
Bench parameters: PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, LOCK_STABLE=8, MAX_RETRIES=3.
- **Normal bring-up:** release `rst`; raise `pll_locked` 5 cycles after `pll_rst` falls and hold it. Required: `pll_rst` high exactly 4 cycles; `ready`=1 and `sys_rst`=0 exactly 2+1+8 cycles after the `pll_locked` rise; `retry_cnt`=0.
- **Timeout exhaustion:** hold `pll_locked`=0. Required: three 4-cycle `pll_rst` pulses separated by 20-cycle gaps; then `fail`=1, `retry_cnt`=3, `pll_rst`=1 held indefinitely.
- **Stabilise glitch:** drop `pll_locked` for one cycle 5 cycles into STABILIZE. Required: `retry_cnt`=1; a new 4-cycle `pll_rst` pulse; `ready` never asserts until a clean 8-cycle stable lock.
- **Lock loss in RUN:** from RUN, drop `pll_locked`. Required: on the 3rd edge, `lock_lost` is a 1-cycle pulse, `sys_rst`=1 and `ready`=0, `pll_rst`=1 for 4 cycles, `retry_cnt` stays 0; relock restores `ready`.
- **Restart from FAIL:** pulse `restart` in FAIL. Required: next edge `fail`=0, `retry_cnt`=0, `pll_rst`=1; a full sequence follows.
- **Reset mid-sequence:** assert `rst` for one cycle during STABILIZE at count 6. Required: next edge all reset values; `pll_rst` is high for 4 cycles after release.
